uart_key_rx: RTL and testbench

//  UART 8N1 receiver plus 256-bit key assembler; the receiving end of the wallet's serial link.

---
 rtl/uart_key_rx_if.sv | 24 ++
 rtl/uart_key_rx.sv | 133 +++++++++++++
 tb/tb_uart_key_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_key_rx_if.sv
// Serial-link bundle between the wallet UART key receiver and its host.
// The master drives the line and the clear request; the slave (receiver) returns bytes and the key.
`timescale 1ns/1ps
interface uart_key_rx_if #(
    parameter int KEY_BYTES = 32
);
    logic                     rx_i;
    logic                     key_clr_i;
    logic [7:0]               rx_byte_o;
    logic                     rx_dv_o;
    logic                     frame_err_o;
    logic [5:0]               byte_cnt_o;
    logic [KEY_BYTES*8-1:0]   key_o;
    logic                     key_valid_o;

    modport master (
        output rx_i, key_clr_i,
        input  rx_byte_o, rx_dv_o, frame_err_o, byte_cnt_o, key_o, key_valid_o
    );
    modport slave (
        input  rx_i, key_clr_i,
        output rx_byte_o, rx_dv_o, frame_err_o, byte_cnt_o, key_o, key_valid_o
    );
endinterface

// File: rtl/uart_key_rx.sv
// UART 8N1 receiver that packs KEY_BYTES consecutive good bytes into a key, first byte in key_o[7:0].
// Partial key material is zeroed on framing error, idle gap, clear request or reset; never held.
`timescale 1ns/1ps
module uart_key_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int KEY_BYTES    = 32,
    parameter int GAP_BITS     = 20
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_key_rx_if.slave  bus
);
    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int GAP_LIM = GAP_BITS * CLKS_PER_BIT;
    localparam int GW      = $clog2(GAP_LIM);
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIM - 1);
    localparam logic [5:0]    FULL     = 6'(KEY_BYTES);
    localparam logic [5:0]    FULL_M1  = 6'(KEY_BYTES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t                 state;
    logic                   rx_meta, rxs;
    logic [CW-1:0]          clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic [GW-1:0]          gap_cnt;
    logic [7:0]             rx_byte_q;
    logic                   rx_dv_q, frame_err_q, key_valid_q;
    logic [5:0]             byte_cnt_q;
    logic [KEY_BYTES*8-1:0] key_q;

    logic stop_smp, byte_ok, byte_bad, gap_act, gap_hit;

    assign stop_smp = (state == STOP) && (clk_cnt == LAST);
    assign byte_ok  = stop_smp && rxs;
    assign byte_bad = stop_smp && !rxs;
    // A frame is "partial" only strictly between empty and full.
    assign gap_act  = (byte_cnt_q != 6'd0) && (byte_cnt_q != FULL);
    assign gap_hit  = (state == IDLE) && gap_act && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            gap_cnt     <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            key_valid_q <= 1'b0;
            byte_cnt_q  <= '0;
            key_q       <= '0;
        end else begin
            rx_meta     <= bus.rx_i;
            rxs         <= rx_meta;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        if (rxs) begin
                            rx_dv_q   <= 1'b1;
                            rx_byte_q <= shreg;
                            state     <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_HI;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                WAIT_HI: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Gap timer only runs while idle in a partial frame; any START entry leaves IDLE and clears it.
            if ((state == IDLE) && gap_act && !gap_hit) gap_cnt <= gap_cnt + GW'(1);
            else                                        gap_cnt <= '0;

            if (bus.key_clr_i) begin
                key_q       <= '0;
                byte_cnt_q  <= '0;
                key_valid_q <= 1'b0;
            end else if (byte_ok && !key_valid_q) begin
                key_q[{byte_cnt_q, 3'b000} +: 8] <= shreg;
                byte_cnt_q <= byte_cnt_q + 6'd1;
                if (byte_cnt_q == FULL_M1) key_valid_q <= 1'b1;
            end else if ((byte_bad || gap_hit) && gap_act) begin
                key_q      <= '0;
                byte_cnt_q <= '0;
            end
        end
    end

    assign bus.rx_byte_o   = rx_byte_q;
    assign bus.rx_dv_o     = rx_dv_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.byte_cnt_o  = byte_cnt_q;
    assign bus.key_o       = key_q;
    assign bus.key_valid_o = key_valid_q;
endmodule

// File: tb/tb_uart_key_rx.sv
// Directed bench for uart_key_rx at default parameters: latency, key assembly, glitch, framing error, gap, clear, reset.
`timescale 1ns/1ps
module tb_uart_key_rx;
    localparam int CPB = 87;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_key_rx_if #(.KEY_BYTES(32)) bus ();

    uart_key_rx #(.CLKS_PER_BIT(CPB), .KEY_BYTES(32), .GAP_BITS(20)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    logic last_valid = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulses are one cycle wide, so one sample per cycle counts each exactly once.
    always @(negedge clk) begin
        if (bus.rx_dv_o) begin
            dv_cnt++;
            last_valid = bus.key_valid_o;
        end
        if (bus.frame_err_o) fe_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.rx_i = b[k];
            repeat (CPB) @(negedge clk);
        end
        bus.rx_i = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.key_clr_i = 1'b1;
        @(negedge clk);
        bus.key_clr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dv0, fe0;
        logic [255:0] exp_key;

        rst = 1'b1;
        bus.rx_i = 1'b1;
        bus.key_clr_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_dv",    bus.rx_dv_o, 0);
        chk("rst_fe",    bus.frame_err_o, 0);
        chk("rst_byte",  bus.rx_byte_o, 0);
        chk("rst_cnt",   bus.byte_cnt_o, 0);
        chk("rst_key",   bus.key_o, 0);
        chk("rst_valid", bus.key_valid_o, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte, latency from the line edge to the dv pulse
        dv0 = dv_cnt;
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                @(posedge clk); #1; lat++;
                while (!bus.rx_dv_o && lat < 2000) begin
                    @(posedge clk); #1; lat++;
                end
            end
        join
        chk("lat",     lat, 830);
        chk("a5_dv",   dv_cnt - dv0, 1);
        chk("a5_byte", bus.rx_byte_o, 8'hA5);
        chk("a5_cnt",  bus.byte_cnt_o, 1);
        chk("a5_key",  bus.key_o, 256'hA5);
        pulse_clr();
        chk("clr_cnt", bus.byte_cnt_o, 0);

        // Full key 0x00..0x1F
        exp_key = '0;
        dv0 = dv_cnt;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i), 1'b1);
            exp_key[i*8 +: 8] = 8'(i);
            if (i == 30) begin
                chk("k31_valid", bus.key_valid_o, 0);
                chk("k31_cnt",   bus.byte_cnt_o, 31);
            end
        end
        chk("k_dv",        dv_cnt - dv0, 32);
        chk("k_valid_dv",  last_valid, 1);
        chk("k_valid",     bus.key_valid_o, 1);
        chk("k_cnt",       bus.byte_cnt_o, 32);
        chk("k_key",       bus.key_o, exp_key);

        // 33rd byte is reported but frozen out of the key
        send_byte(8'hFF, 1'b1);
        chk("b33_dv",   dv_cnt - dv0, 33);
        chk("b33_byte", bus.rx_byte_o, 8'hFF);
        chk("b33_key",  bus.key_o, exp_key);
        chk("b33_cnt",  bus.byte_cnt_o, 32);

        // Clear with a valid key
        pulse_clr();
        chk("kc_key",   bus.key_o, 0);
        chk("kc_cnt",   bus.byte_cnt_o, 0);
        chk("kc_valid", bus.key_valid_o, 0);

        // 20-cycle low glitch while idle, then a normal byte
        dv0 = dv_cnt; fe0 = fe_cnt;
        bus.rx_i = 1'b0;
        repeat (20) @(negedge clk);
        bus.rx_i = 1'b1;
        repeat (1000) @(negedge clk);
        chk("gl_dv", dv_cnt - dv0, 0);
        chk("gl_fe", fe_cnt - fe0, 0);
        send_byte(8'h3C, 1'b1);
        chk("gl_byte", bus.rx_byte_o, 8'h3C);
        chk("gl_key",  bus.key_o, 256'h3C);
        pulse_clr();

        // Five bytes then a framing error, then a long break
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 1'b1);
        chk("fe_cnt5", bus.byte_cnt_o, 5);
        chk("fe_key5", bus.key_o, 256'h4443424140);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h77, 1'b0);
        chk("fe_pulse", fe_cnt - fe0, 1);
        chk("fe_nodv",  dv_cnt - dv0, 0);
        chk("fe_cnt",   bus.byte_cnt_o, 0);
        chk("fe_key",   bus.key_o, 0);
        repeat (2000) @(negedge clk);
        chk("brk_fe", fe_cnt - fe0, 1);
        chk("brk_dv", dv_cnt - dv0, 0);
        bus.rx_i = 1'b1;
        repeat (100) @(negedge clk);

        // Gap timeout on a partial frame
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("gap_cnt3", bus.byte_cnt_o, 3);
        repeat (1600) @(negedge clk);
        chk("gap_hold", bus.byte_cnt_o, 3);
        chk("gap_keyh", bus.key_o, 256'h332211);
        repeat (200) @(negedge clk);
        chk("gap_cnt", bus.byte_cnt_o, 0);
        chk("gap_key", bus.key_o, 0);

        // Fresh key after the gap
        exp_key = '0;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'hE0 + 8'(i), 1'b1);
            exp_key[i*8 +: 8] = 8'hE0 + 8'(i);
        end
        chk("k2_valid", bus.key_valid_o, 1);
        chk("k2_key",   bus.key_o, exp_key);

        // Reset during bit 4; held until the frame has passed
        dv0 = dv_cnt;
        fork
            send_byte(8'h81, 1'b1);
            begin
                repeat (CPB * 5 + 40) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("mr_key",   bus.key_o, 0);
                chk("mr_valid", bus.key_valid_o, 0);
                chk("mr_cnt",   bus.byte_cnt_o, 0);
            end
        join
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("mr_nodv", dv_cnt - dv0, 0);
        chk("mr_byte", bus.rx_byte_o, 0);
        chk("mr_key2", bus.key_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
